// File: rtl/folded_threshold_unit.sv
// Folded threshold evaluator: popcounts an N-bit vector CHUNK bits per cycle and compares to a threshold.
// Optional early decision when the outcome is already known: define FOLDED_THRESHOLD_EARLY_EXIT_EN.
module folded_threshold_unit #(
  parameter int N = 39,
  parameter int CHUNK = 8,
  localparam int NSLICE = (N + CHUNK - 1) / CHUNK,
  localparam int CW = $clog2(N + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_vec,
  input  logic [CW-1:0] thr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          y,
  output logic [CW-1:0] count
);

  // state | meaning
  // IDLE  | waiting for an input vector
  // ACCUM | adding one slice popcount per cycle
  // DONE  | result presented, waiting for consumer
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int PW = NSLICE * CHUNK;
  localparam logic [CW-1:0] CHUNK_W = CW'(CHUNK);
  localparam logic [CW-1:0] N_W     = CW'(N);

  logic [1:0]    state;
  logic [PW-1:0] vec_sh;
  logic [CW-1:0] thr_q;
  logic [CW-1:0] acc;
  logic [CW-1:0] rem;
  logic [CW-1:0] slice_pc;
  logic [CW-1:0] acc_new;
  logic [CW-1:0] rem_next;
  logic          last;
  logic          decide;

  // The vector is zero-extended and shifted down, so bits past N are always zero.
  always_comb begin
    slice_pc = '0;
    for (int i = 0; i < CHUNK; i++) begin
      slice_pc = slice_pc + CW'(vec_sh[i]);
    end
    acc_new  = acc + slice_pc;
    last     = (rem <= CHUNK_W);
    rem_next = last ? '0 : (rem - CHUNK_W);
`ifdef FOLDED_THRESHOLD_EARLY_EXIT_EN
    decide = last || (acc_new >= thr_q) || ((acc_new + rem_next) < thr_q);
`else
    decide = last;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      vec_sh <= '0;
      thr_q  <= '0;
      acc    <= '0;
      rem    <= '0;
      count  <= '0;
      y      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            vec_sh <= PW'(in_vec);
            thr_q  <= thr;
            acc    <= '0;
            rem    <= N_W;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc    <= acc_new;
          rem    <= rem_next;
          vec_sh <= vec_sh >> CHUNK;
          if (decide) begin
            count <= acc_new;
            y     <= (acc_new >= thr_q);
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_folded_threshold_unit.sv
// Scoreboard bench for folded_threshold_unit: driver pushes model results, monitor pops on out_valid.
module tb_folded_threshold_unit;
  localparam int N = 39;
  localparam int CHUNK = 8;
  localparam int NSLICE = (N + CHUNK - 1) / CHUNK;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_vec;
  logic [CW-1:0] thr;
  logic          out_valid;
  logic          out_ready;
  logic          y;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic          y;
    logic [CW-1:0] cnt;
    int            lat;
    int            acc;
  } exp_t;
  exp_t sbq[$];

  folded_threshold_unit #(.N(N), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .thr(thr), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .count(count)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: count ones among the bits seen so far, slice by slice.
  function automatic exp_t model(input logic [N-1:0] v, input int t);
    exp_t e;
    int c;
    int proc;
    c = 0;
    e.lat = 0;
    for (int k = 1; k <= NSLICE; k++) begin
      proc = (k * CHUNK < N) ? k * CHUNK : N;
      c = 0;
      for (int i = 0; i < proc; i++) c += int'(v[i]);
      e.lat = k;
      if (k == NSLICE) break;
`ifdef FOLDED_THRESHOLD_EARLY_EXIT_EN
      if (c >= t || c + (N - proc) < t) break;
`endif
    end
    e.y = (c >= t);
    e.cnt = c[CW-1:0];
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    case ($urandom_range(0, 2))
      0: r = a & b;
      1: r = a | b;
      default: r = a;
    endcase
    return r[N-1:0];
  endfunction

  task automatic run(input logic [N-1:0] v, input int t, input int hold_in);
    exp_t e;
    bit ok;
    int w;
    int hold;
    hold = hold_in;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_ready", in_ready, 1);
    in_vec = v;
    thr = t[CW-1:0];
    in_valid = 1'b1;
    out_ready = (hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    e = model(v, t);
    e.acc = cyc;
    sbq.push_back(e);
    @(negedge clk);
    in_vec = rand_vec();
    thr = 6'($urandom_range(0, 63));
    in_valid = 1'($urandom_range(0, 1));
    ok = 0;
    for (int c2 = 0; c2 < 300; c2++) begin
      if (out_valid && hold > 0) begin
        out_ready = 1'b0;
        repeat (hold) begin
          @(negedge clk);
          chk("hold_in_ready", in_ready, 0);
          chk("hold_out_valid", out_valid, 1);
        end
        hold = 0;
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("ret_in_ready", in_ready, 1);
        chk("ret_out_valid", out_valid, 0);
        ok = 1;
        break;
      end
      @(negedge clk);
      out_ready = (hold > 0) ? 1'b0 : 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
    end
    if (!ok) chk("result_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  // Monitor: pop on each new result, then require it to stay stable while held.
  initial begin
    bit seen;
    exp_t e;
    exp_t h;
    seen = 0;
    h.y = 1'b0;
    h.cnt = '0;
    forever begin
      @(negedge clk);
      if (rst || !out_valid) begin
        seen = 0;
      end else if (!seen) begin
        seen = 1;
        if (sbq.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("y", y, e.y);
          chk("count", count, e.cnt);
          chk("latency", cyc - e.acc, e.lat);
          h = e;
        end
      end else begin
        chk("stable_y", y, h.y);
        chk("stable_count", count, h.cnt);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_vec = '0;
    thr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_count", count, 0);

    run(39'h7FFFFFFFFF, 20, -1);
    run(39'h00000FFFFF, 20, -1);
    run(39'h000007FFFF, 20, -1);
    run(39'h7FFFF80000, 20, -1);
    run(39'h0000000000, 0, -1);
    run(39'h7FFFFFFFFF, 40, -1);
    run(39'h0000000000, 20, -1);
    run(39'h00000FFFFF, 20, 10);

    // Reset two slices into an accumulation.
    @(negedge clk);
    in_vec = 39'h00000FFFFF;
    thr = 6'd20;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_accepted", in_ready, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_vec = rand_vec();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_y", y, 0);
    run(39'h00000FFFFF, 20, -1);

    for (int k = 0; k < 40; k++) begin
      run(rand_vec(), int'($urandom_range(0, N + 1)), (k % 10 == 3) ? 4 : -1);
    end

    w = 0;
    while (sbq.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("sb_drain", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
